iic_slave: RTL
==============

IIC_SLAVE -- requirements
Module: iic_slave

Interface
REQ-001 The module SHALL have parameter ADDR, default 7'h50, meaning the 7-bit bus address it responds to.
REQ-002 The module SHALL have parameter CLK_FREQ, default 50_000_000, meaning the CLK frequency in Hz; CLK SHALL be at least 16x the bus SCL rate.
REQ-003 The module SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-004 The module SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port SCL  input  1  bus clock from the master, asynchronous to CLK.
REQ-006 The module SHALL have port SDA_In  input  1  bus data line as seen at the pad, asynchronous to CLK.
REQ-007 The module SHALL have port SDA_Oe  output  1  1 = pull SDA low, 0 = release the line (open-drain).
REQ-008 The module SHALL have port Rx_Data  output  8  last data byte written by the master.
REQ-009 The module SHALL have port Rx_Valid  output  1  one-CLK pulse when Rx_Data is updated.
REQ-010 The module SHALL have port Tx_Data  input  8  byte to return on a master read; captured on each Tx_Req.
REQ-011 The module SHALL have port Tx_Req  output  1  one-CLK pulse when Tx_Data is captured.
REQ-012 The module SHALL have port Busy  output  1  high from an address match until STOP, START or reset.

Function
REQ-013 SCL and SDA_In SHALL each pass through a 2-flop synchronizer, plus one history flop for edge detection; all bus events below refer to these synchronized signals.
REQ-014 START SHALL be SDA falling while SCL high; STOP SHALL be SDA rising while SCL high.
REQ-015 Bits SHALL be sampled on the SCL rising edge, MSB first; SDA_Oe SHALL change only in the CLK cycle after an SCL falling edge is detected.
REQ-016 The FSM SHALL have states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK and IGNORE.
REQ-017 From any state, START SHALL go to ADDR with a cleared bit counter, and STOP SHALL go to IDLE; both SHALL release SDA_Oe and clear Busy.
REQ-018 ADDR: after 8 bits, if bits[7:1] == ADDR, go to ADDR_ACK and set Busy; otherwise go to IGNORE without acknowledging.
REQ-019 ADDR_ACK: drive SDA_Oe=1 for one SCL low/high period; on the following SCL fall, go to WRITE if R/W=0, or to READ if R/W=1.
REQ-020 Entry to READ SHALL pulse Tx_Req, capture Tx_Data in the same cycle, and drive the MSB.
REQ-021 WRITE: after 8 sampled bits, Rx_Data SHALL update and Rx_Valid SHALL pulse one CLK after the 8th SCL rise is detected; then go to WRITE_ACK and drive SDA_Oe=1 for one bit period.
REQ-022 WRITE_ACK SHALL return to WRITE for the next byte; bytes per transaction SHALL be unbounded.
REQ-023 READ: SDA_Oe SHALL equal the inverse of the current bit; after 8 bits, release SDA and go to READ_ACK.
REQ-024 READ_ACK: on master ACK (SDA low at SCL rise), go to READ with a new Tx_Req capture; on NACK, go to IGNORE.
REQ-025 IGNORE SHALL keep SDA_Oe=0 and wait only for START or STOP.
REQ-026 The bit counter SHALL be 3 bits wide and wrap from 7 to 0 at each byte boundary.
REQ-027 If START or STOP coincides with an SCL edge in the same CLK cycle, START or STOP SHALL take priority.

Reset
REQ-028 While RST=1, the FSM SHALL be IDLE and SDA_Oe, Rx_Data, Rx_Valid, Tx_Req and Busy SHALL all be 0, with SDA released asynchronously even mid-transfer.
REQ-029 After reset, the synchronizers SHALL hold 1, so that no false START is reported.

Verification
REQ-030 Write 0xA0, 0x3C, STOP -> SDA_Oe low in both ACK slots, Rx_Data=0x3C, exactly one Rx_Valid, Busy low after STOP.
REQ-031 Address 0xA2 (mismatch), 0x55 -> SDA_Oe never asserted, no Rx_Valid, Busy stays 0.
REQ-032 Read 0xA1 with Tx_Data=0x96, master ACK, Tx_Data=0x0F, master NACK -> SDA carries 0x96 then 0x0F, two Tx_Req pulses, IGNORE then IDLE on STOP.
REQ-033 Write 0xA0, 0x11, repeated START, 0xA1 -> Rx_Data=0x11, then a read byte is driven after the ACK.
REQ-034 RST=1 while driving a READ 0 bit -> SDA_Oe drops asynchronously, all outputs 0, next START is decoded normally.
REQ-035 STOP injected after 4 bits of a WRITE byte -> no Rx_Valid, SDA released, FSM in IDLE.

Source files
------------

// File: rtl/iic_slave_if.sv
// Bus-side signal bundle for the I2C slave: pad-level SCL/SDA plus the
// byte-level receive/transmit handshake toward the local logic.
interface iic_slave_if;
  logic       SCL;
  logic       SDA_In;
  logic       SDA_Oe;
  logic [7:0] Rx_Data;
  logic       Rx_Valid;
  logic [7:0] Tx_Data;
  logic       Tx_Req;
  logic       Busy;

  modport slave (
    input  SCL, SDA_In, Tx_Data,
    output SDA_Oe, Rx_Data, Rx_Valid, Tx_Req, Busy
  );

  modport master (
    output SCL, SDA_In, Tx_Data,
    input  SDA_Oe, Rx_Data, Rx_Valid, Tx_Req, Busy
  );
endinterface

// File: rtl/iic_slave.sv
// Oversampling I2C slave: synchronizes SCL/SDA into the CLK domain, decodes
// START/STOP, matches a 7-bit address and moves bytes in both directions.
module iic_slave #(
  parameter logic [6:0] ADDR     = 7'h50,
  parameter int         CLK_FREQ = 50_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  iic_slave_if.slave  bus
);

  // 16x a 100 kHz bus is the slowest usable system clock.
  if (CLK_FREQ < 1_600_000) begin : g_clk_too_slow
    $error("iic_slave: CLK_FREQ too low for 16x oversampling");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        sda_oe, oe_n;
  logic        ack_phase, ack_n;
  logic        busy, busy_n;
  logic [7:0]  rx_data, rx_data_n;
  logic        rx_valid, rx_valid_n;
  logic        tx_req, tx_req_n;
  logic [6:0]  rx_shift, rx_sh_n;
  logic [6:0]  tx_shift, tx_sh_n;

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Stage p0/p1: synchronizer, p2: history for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      {scl_p0, scl_p1, scl_p2} <= 3'b111;
      {sda_p0, sda_p1, sda_p2} <= 3'b111;
    end else begin
      {scl_p0, scl_p1, scl_p2} <= {bus.SCL, scl_p0, scl_p1};
      {sda_p0, sda_p1, sda_p2} <= {bus.SDA_In, sda_p0, sda_p1};
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    oe_n       = sda_oe;
    ack_n      = ack_phase;
    busy_n     = busy;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    rx_sh_n    = rx_shift;
    tx_sh_n    = tx_shift;
    if (start_det || stop_det) begin
      state_n = start_det ? S_ADDR : S_IDLE;
      cnt_n   = 3'd0;
      oe_n    = 1'b0;
      ack_n   = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_WRITE: begin
          if (scl_rise) begin
            rx_sh_n = {rx_shift[5:0], sda_p1};
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              ack_n = 1'b0;
              if (state == S_WRITE) begin
                rx_data_n  = {rx_shift, sda_p1};
                rx_valid_n = 1'b1;
                state_n    = S_WRITE_ACK;
              end else if (rx_shift == ADDR) begin
                busy_n  = 1'b1;
                state_n = S_ADDR_ACK;
              end else begin
                state_n = S_IGNORE;
              end
            end
          end
        end
        // First SCL fall asserts the ACK, the second one ends the ACK bit.
        S_ADDR_ACK, S_WRITE_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              oe_n  = 1'b1;
              ack_n = 1'b1;
            end else begin
              ack_n = 1'b0;
              if (state == S_WRITE_ACK || !rx_shift[0]) begin
                oe_n    = 1'b0;
                state_n = S_WRITE;
              end else begin
                state_n  = S_READ;
                tx_req_n = 1'b1;
                tx_sh_n  = bus.Tx_Data[6:0];
                oe_n     = ~bus.Tx_Data[7];
              end
            end
          end
        end
        S_READ: begin
          if (scl_rise) begin
            cnt_n = cnt + 3'd1;
          end else if (scl_fall) begin
            if (cnt == 3'd0) begin
              oe_n    = 1'b0;
              ack_n   = 1'b0;
              state_n = S_READ_ACK;
            end else begin
              oe_n    = ~tx_shift[6];
              tx_sh_n = {tx_shift[5:0], 1'b0};
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise) begin
            if (!sda_p1) ack_n = 1'b1;
            else         state_n = S_IGNORE;
          end else if (scl_fall && ack_phase) begin
            ack_n    = 1'b0;
            state_n  = S_READ;
            tx_req_n = 1'b1;
            tx_sh_n  = bus.Tx_Data[6:0];
            oe_n     = ~bus.Tx_Data[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      sda_oe    <= 1'b0;
      ack_phase <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sda_oe    <= oe_n;
      ack_phase <= ack_n;
      busy      <= busy_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      tx_req    <= tx_req_n;
    end
  end

  always_ff @(posedge CLK) begin
    rx_shift <= rx_sh_n;
    tx_shift <= tx_sh_n;
  end

  assign bus.SDA_Oe   = sda_oe;
  assign bus.Rx_Data  = rx_data;
  assign bus.Rx_Valid = rx_valid;
  assign bus.Tx_Req   = tx_req;
  assign bus.Busy     = busy;

endmodule
